// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
//   Shared definitions for the parametrised Galois LFSR:
//     - word_t            : widest supported LFSR word (32 bits)
//     - op_e              : per-cycle operation selected by load/en priority
//     - lfsr_default_taps : maximal-length Galois feedback masks, WIDTH 2..32
//     - lfsr_width_mask   : all-ones mask of the active state width
//     - lfsr_step         : one Galois step f(s)
//     - lfsr_is_valid_cfg : elaboration-time parameter sanity check
// ----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] word_t;

    // What the register bank does on a given clock (reset is handled apart,
    // since it is asynchronous).
    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_STEP = 2'd1,
        OP_LOAD = 2'd2
    } op_e;

    // Feedback masks are the primitive polynomial without its x^WIDTH term,
    // so bit 0 (the +1 term) is always set.
    function automatic word_t lfsr_default_taps(input int unsigned width);
        word_t taps;
        case (width)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0003;
            4:       taps = 32'h0000_0003;
            5:       taps = 32'h0000_0005;
            6:       taps = 32'h0000_0003;
            7:       taps = 32'h0000_0003;
            8:       taps = 32'h0000_001D;
            9:       taps = 32'h0000_0011;
            10:      taps = 32'h0000_0009;
            11:      taps = 32'h0000_0005;
            12:      taps = 32'h0000_0053;
            13:      taps = 32'h0000_001B;
            14:      taps = 32'h0000_0443;
            15:      taps = 32'h0000_0003;
            16:      taps = 32'h0000_100B;
            17:      taps = 32'h0000_0009;
            18:      taps = 32'h0000_0081;
            19:      taps = 32'h0000_0027;
            20:      taps = 32'h0000_0009;
            21:      taps = 32'h0000_0005;
            22:      taps = 32'h0000_0003;
            23:      taps = 32'h0000_0021;
            24:      taps = 32'h0000_0087;
            25:      taps = 32'h0000_0009;
            26:      taps = 32'h0000_0047;
            27:      taps = 32'h0000_0027;
            28:      taps = 32'h0000_0009;
            29:      taps = 32'h0000_0005;
            30:      taps = 32'h0000_0053;
            31:      taps = 32'h0000_0009;
            32:      taps = 32'h0040_0007;
            default: taps = 32'h0000_0003;
        endcase
        return taps;
    endfunction

    function automatic word_t lfsr_width_mask(input int unsigned width);
        word_t mask;
        if (width >= MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (word_t'(1) << width) - word_t'(1);
        end
        return mask;
    endfunction

    // f(s) = {s[W-2:0],1'b0} ^ (s[W-1] ? taps : 0), evaluated inside a
    // 32-bit word; callers truncate back to their own width.
    function automatic word_t lfsr_step(input word_t s, input word_t taps,
                                        input int unsigned width);
        word_t mask;
        logic  msb;
        mask = lfsr_width_mask(width);
        msb  = ((s >> (width - 1)) & word_t'(1)) != '0;
        return ((s << 1) & mask) ^ (msb ? (taps & mask) : '0);
    endfunction

    // A zero state would lock the register forever, so the seed must be
    // non-zero and the +1 tap must be present (that keeps f injective and
    // therefore never maps a non-zero state to zero). The counter must be
    // wide enough to hold STEPS itself.
    function automatic bit lfsr_is_valid_cfg(input int unsigned width,
                                             input word_t       taps,
                                             input word_t       seed,
                                             input int unsigned steps,
                                             input int unsigned cnt_w);
        word_t mask;
        bit    ok;
        ok = 1'b1;
        if (width < MIN_WIDTH || width > MAX_WIDTH) begin
            ok = 1'b0;
        end else begin
            mask = lfsr_width_mask(width);
            if (taps[0] == 1'b0)             ok = 1'b0;
            if ((taps & ~mask) != '0)        ok = 1'b0;
            if ((seed & mask) == '0)         ok = 1'b0;
            if ((seed & ~mask) != '0)        ok = 1'b0;
            if (steps == 0 || steps > width) ok = 1'b0;
        end
        if (cnt_w == 0 || cnt_w > 32) begin
            ok = 1'b0;
        end else if (longint'(steps) >= (longint'(1) << cnt_w)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/lfsr_step_chain.sv
// ----------------------------------------------------------------------------
// lfsr_step_chain
//   Combinational STEPS-deep unroll of the Galois step function.
//   Ports:
//     state      in   WIDTH          s(0), the current register value
//     stages     out  STEPS x WIDTH  stages[k] = s(k+1)
//     next_state out  WIDTH          s(STEPS)
//     out_bits   out  STEPS          out_bits[k] = s(k)[WIDTH-1]
// ----------------------------------------------------------------------------
module lfsr_step_chain
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b0011),
    parameter int unsigned      STEPS = 1
) (
    input  logic [WIDTH-1:0]            state,
    output logic [STEPS-1:0][WIDTH-1:0] stages,
    output logic [WIDTH-1:0]            next_state,
    output logic [STEPS-1:0]            out_bits
);

    // Each unroll stage owns its own input/output nets so the chain is a
    // plain feed-forward path with no self-referencing vector.
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;

        if (gi == 0) begin : g_first
            assign cur = state;
        end else begin : g_rest
            assign cur = g_step[gi-1].nxt;
        end

        assign nxt          = WIDTH'(lfsr_step(word_t'(cur), word_t'(TAPS), WIDTH));
        assign out_bits[gi] = cur[WIDTH-1];
        assign stages[gi]   = nxt;
    end

    assign next_state = g_step[STEPS-1].nxt;

endmodule

// File: rtl/lfsr_galois_param.sv
// ----------------------------------------------------------------------------
// lfsr_galois_param
//   Parametrised Galois LFSR with step enable, seed load (zero loads are
//   replaced by SEED and flagged), serial output bits and a self-measured
//   period through the start value.
//   Ports:
//     clk          in   1      rising-edge clock
//     rst          in   1      asynchronous, active-high reset
//     en           in   1      advance STEPS steps this cycle
//     load         in   1      load load_val (wins over en)
//     load_val     in   WIDTH  value to load
//     state        out  WIDTH  current LFSR state
//     out_bits     out  STEPS  MSBs shifted out by the last advance, bit 0 first
//     wrap         out  1      pulse: last advance passed through start value
//     period       out  CNT_W  measured sequence length in single steps
//     period_valid out  1      period holds a measurement
//     lockup_err   out  1      pulse: a zero load was rejected
// ----------------------------------------------------------------------------
module lfsr_galois_param
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    // For WIDTH=4 the table entry is 4'b0011 (x^4+x+1).
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int unsigned      STEPS = 1,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic [STEPS-1:0] out_bits,
    output logic             wrap,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             lockup_err
);

    if (!lfsr_is_valid_cfg(WIDTH, word_t'(TAPS), word_t'(SEED), STEPS, CNT_W)) begin : g_bad_cfg
        $error("lfsr_galois_param: invalid WIDTH/TAPS/SEED/STEPS/CNT_W combination");
    end

    localparam int unsigned    J_W     = $clog2(STEPS + 1);
    localparam int unsigned    SUM_W   = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] state_reg,        state_next;
    logic [WIDTH-1:0] start_reg,        start_next;
    logic [CNT_W-1:0] step_cnt_reg,     step_cnt_next;
    logic [CNT_W-1:0] period_reg,       period_next;
    logic             period_valid_reg, period_valid_next;
    logic [STEPS-1:0] out_bits_reg,     out_bits_next;
    logic             wrap_reg,         wrap_next;
    logic             lockup_reg,       lockup_next;

    // ------------------------------------------------------------------
    // Unrolled advance
    // ------------------------------------------------------------------
    logic [STEPS-1:0][WIDTH-1:0] stages;
    logic [WIDTH-1:0]            chain_state;
    logic [STEPS-1:0]            chain_out;

    lfsr_step_chain #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) u_chain (
        .state      (state_reg),
        .stages     (stages),
        .next_state (chain_state),
        .out_bits   (chain_out)
    );

    // ------------------------------------------------------------------
    // Start-value detection: j = smallest k in 1..STEPS with s(k)==start.
    // The selection runs from the last stage back to the first so that
    // the lowest matching stage wins.
    // ------------------------------------------------------------------
    logic [STEPS-1:0] hit;
    logic [J_W-1:0]   first_j;
    logic             found;

    for (genvar gi = 0; gi < STEPS; gi++) begin : g_hit
        logic [J_W-1:0] j_sel;

        assign hit[gi] = (stages[gi] == start_reg);

        if (gi == STEPS - 1) begin : g_last
            assign j_sel = hit[gi] ? J_W'(gi + 1) : '0;
        end else begin : g_mid
            assign j_sel = hit[gi] ? J_W'(gi + 1) : g_hit[gi+1].j_sel;
        end
    end

    assign first_j = g_hit[0].j_sel;
    assign found   = |hit;

    // ------------------------------------------------------------------
    // Counter arithmetic
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] cnt_sum;
    logic [CNT_W-1:0] cnt_sat;
    logic [CNT_W-1:0] period_hit;
    logic [CNT_W-1:0] cnt_rest;

    // The extra carry bit detects overflow so the counter sticks at
    // all-ones instead of wrapping to a small, misleading value.
    assign cnt_sum    = {1'b0, step_cnt_reg} + SUM_W'(STEPS);
    assign cnt_sat    = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
    assign period_hit = step_cnt_reg + CNT_W'(first_j);
    // Steps taken after passing start in this same advance.
    assign cnt_rest   = CNT_W'(STEPS) - CNT_W'(first_j);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    op_e op;

    always_comb begin
        if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_STEP;
        end else begin
            op = OP_IDLE;
        end
    end

    always_comb begin
        state_next        = state_reg;
        start_next        = start_reg;
        step_cnt_next     = step_cnt_reg;
        period_next       = period_reg;
        period_valid_next = period_valid_reg;
        out_bits_next     = out_bits_reg;
        wrap_next         = 1'b0;
        lockup_next       = 1'b0;

        case (op)
            OP_LOAD: begin
                if (load_val != '0) begin
                    state_next = load_val;
                    start_next = load_val;
                end else begin
                    // A zero state would never leave zero; fall back to SEED.
                    state_next  = SEED;
                    start_next  = SEED;
                    lockup_next = 1'b1;
                end
                step_cnt_next     = '0;
                period_next       = '0;
                period_valid_next = 1'b0;
                out_bits_next     = '0;
            end

            OP_STEP: begin
                state_next    = chain_state;
                out_bits_next = chain_out;
                if (found) begin
                    wrap_next         = 1'b1;
                    period_next       = period_hit;
                    period_valid_next = 1'b1;
                    step_cnt_next     = cnt_rest;
                end else begin
                    step_cnt_next = cnt_sat;
                end
            end

            default: begin
                // Idle: hold everything; pulses already defaulted to 0.
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= SEED;
            start_reg        <= SEED;
            step_cnt_reg     <= '0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            out_bits_reg     <= '0;
            wrap_reg         <= 1'b0;
            lockup_reg       <= 1'b0;
        end else begin
            state_reg        <= state_next;
            start_reg        <= start_next;
            step_cnt_reg     <= step_cnt_next;
            period_reg       <= period_next;
            period_valid_reg <= period_valid_next;
            out_bits_reg     <= out_bits_next;
            wrap_reg         <= wrap_next;
            lockup_reg       <= lockup_next;
        end
    end

    assign state        = state_reg;
    assign out_bits     = out_bits_reg;
    assign wrap         = wrap_reg;
    assign period       = period_reg;
    assign period_valid = period_valid_reg;
    assign lockup_err   = lockup_reg;

endmodule

// File: tb/tb_lfsr_galois_param.sv
// ----------------------------------------------------------------------------
// tb_lfsr_galois_param
//   Four instances share clk/rst/en/load:
//     u0: defaults (WIDTH 4, x^4+x+1, STEPS 1)
//     u1: WIDTH 4, STEPS 2
//     u2: WIDTH 4, TAPS 4'b0101 (non-maximal, cycle of 6)
//     u3: WIDTH 8, TAPS 8'h1D, STEPS 3
//   A single-step reference model tracks each instance; directed steps add
//   fixed expected values from the known sequences.
// ----------------------------------------------------------------------------
module tb_lfsr_galois_param;

    localparam int NI = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] load_val4;
    logic [7:0] load_val8;

    logic [3:0]  a_state;  logic [0:0] a_out; logic a_wrap; logic [15:0] a_period; logic a_pv; logic a_lock;
    logic [3:0]  b_state;  logic [1:0] b_out; logic b_wrap; logic [15:0] b_period; logic b_pv; logic b_lock;
    logic [3:0]  c_state;  logic [0:0] c_out; logic c_wrap; logic [15:0] c_period; logic c_pv; logic c_lock;
    logic [7:0]  d_state;  logic [2:0] d_out; logic d_wrap; logic [15:0] d_period; logic d_pv; logic d_lock;

    lfsr_galois_param u0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val4),
        .state(a_state), .out_bits(a_out), .wrap(a_wrap), .period(a_period),
        .period_valid(a_pv), .lockup_err(a_lock)
    );

    lfsr_galois_param #(.WIDTH(4), .TAPS(4'b0011), .SEED(4'b0001), .STEPS(2), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val4),
        .state(b_state), .out_bits(b_out), .wrap(b_wrap), .period(b_period),
        .period_valid(b_pv), .lockup_err(b_lock)
    );

    lfsr_galois_param #(.WIDTH(4), .TAPS(4'b0101), .SEED(4'b0001), .STEPS(1), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val4),
        .state(c_state), .out_bits(c_out), .wrap(c_wrap), .period(c_period),
        .period_valid(c_pv), .lockup_err(c_lock)
    );

    lfsr_galois_param #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .STEPS(3), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val8),
        .state(d_state), .out_bits(d_out), .wrap(d_wrap), .period(d_period),
        .period_valid(d_pv), .lockup_err(d_lock)
    );

    // ------------------------------------------------------------------
    // Reference model: walks one single step at a time, counting steps
    // since the start value was last seen.
    // ------------------------------------------------------------------
    int unsigned m_w     [NI] = '{4, 4, 4, 8};
    int unsigned m_taps  [NI] = '{32'h3, 32'h3, 32'h5, 32'h1D};
    int unsigned m_seed  [NI] = '{1, 1, 1, 1};
    int unsigned m_steps [NI] = '{1, 2, 1, 3};

    int unsigned m_state  [NI];
    int unsigned m_start  [NI];
    int unsigned m_cnt    [NI];
    int unsigned m_period [NI];
    int unsigned m_out    [NI];
    bit          m_wrap   [NI];
    bit          m_pv     [NI];
    bit          m_lock   [NI];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic model_reset(input int i);
        m_state[i]  = m_seed[i];
        m_start[i]  = m_seed[i];
        m_cnt[i]    = 0;
        m_period[i] = 0;
        m_out[i]    = 0;
        m_wrap[i]   = 1'b0;
        m_pv[i]     = 1'b0;
        m_lock[i]   = 1'b0;
    endtask

    task automatic model_edge(input int i);
        int unsigned mask;
        int unsigned lv;
        int unsigned msb;
        mask = (32'd1 << m_w[i]) - 1;
        if (rst) begin
            model_reset(i);
        end else if (load) begin
            lv = (i == 3) ? 32'(load_val8) : 32'(load_val4);
            if (lv != 0) begin
                m_state[i] = lv;
                m_start[i] = lv;
                m_lock[i]  = 1'b0;
            end else begin
                m_state[i] = m_seed[i];
                m_start[i] = m_seed[i];
                m_lock[i]  = 1'b1;
            end
            m_cnt[i]    = 0;
            m_period[i] = 0;
            m_pv[i]     = 1'b0;
            m_out[i]    = 0;
            m_wrap[i]   = 1'b0;
        end else if (en) begin
            m_wrap[i] = 1'b0;
            m_lock[i] = 1'b0;
            m_out[i]  = 0;
            for (int k = 0; k < int'(m_steps[i]); k++) begin
                msb        = (m_state[i] >> (m_w[i] - 1)) & 1;
                m_out[i]   = m_out[i] | (msb << k);
                m_state[i] = ((m_state[i] << 1) & mask) ^ ((msb != 0) ? m_taps[i] : 0);
                if (m_cnt[i] != 32'hFFFF) m_cnt[i] = m_cnt[i] + 1;
                // Only the first pass through start in an advance is reported.
                if (!m_wrap[i] && m_state[i] == m_start[i]) begin
                    m_wrap[i]   = 1'b1;
                    m_pv[i]     = 1'b1;
                    m_period[i] = m_cnt[i] & 32'hFFFF;
                    m_cnt[i]    = 0;
                end
            end
        end else begin
            m_wrap[i] = 1'b0;
            m_lock[i] = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic get_dut(input int i, output logic [31:0] st, output logic [31:0] ob,
                           output logic [31:0] pe, output logic wr, output logic pv,
                           output logic lk);
        case (i)
            0: begin st = 32'(a_state); ob = 32'(a_out); pe = 32'(a_period); wr = a_wrap; pv = a_pv; lk = a_lock; end
            1: begin st = 32'(b_state); ob = 32'(b_out); pe = 32'(b_period); wr = b_wrap; pv = b_pv; lk = b_lock; end
            2: begin st = 32'(c_state); ob = 32'(c_out); pe = 32'(c_period); wr = c_wrap; pv = c_pv; lk = c_lock; end
            default: begin st = 32'(d_state); ob = 32'(d_out); pe = 32'(d_period); wr = d_wrap; pv = d_pv; lk = d_lock; end
        endcase
    endtask

    task automatic check_all(input string ph);
        logic [31:0] st, ob, pe;
        logic        wr, pv, lk;
        for (int i = 0; i < NI; i++) begin
            get_dut(i, st, ob, pe, wr, pv, lk);
            chk($sformatf("%s.u%0d.state", ph, i),        st,        m_state[i]);
            chk($sformatf("%s.u%0d.out_bits", ph, i),     ob,        m_out[i]);
            chk($sformatf("%s.u%0d.wrap", ph, i),         32'(wr),   32'(m_wrap[i]));
            chk($sformatf("%s.u%0d.period", ph, i),       pe,        m_period[i]);
            chk($sformatf("%s.u%0d.period_valid", ph, i), 32'(pv),   32'(m_pv[i]));
            chk($sformatf("%s.u%0d.lockup_err", ph, i),   32'(lk),   32'(m_lock[i]));
        end
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic cycle(input string ph);
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_edge(i);
        #1;
        cyc++;
        $display("cyc %0d %s rst=%0b load=%0b en=%0b lv4=%h lv8=%h | u0 %h w%0b p%0d | u1 %h | u2 %h | u3 %h",
                 cyc, ph, rst, load, en, load_val4, load_val8,
                 a_state, a_wrap, a_period, b_state, c_state, d_state);
        check_all(ph);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [3:0] exp_seq [15];

    initial begin
        exp_seq = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                    4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

        rst       = 1'b1;
        en        = 1'b0;
        load      = 1'b0;
        load_val4 = 4'h0;
        load_val8 = 8'h00;
        for (int i = 0; i < NI; i++) model_reset(i);

        // Reset state
        cycle("reset");
        cycle("reset");
        chk("reset.state", 32'(a_state), 32'h1);
        chk("reset.period_valid", 32'(a_pv), 32'h0);
        #1 rst = 1'b0;

        // Free-running sequence from the seed
        en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cycle("seq");
            chk($sformatf("seq.u0.state[%0d]", k), 32'(a_state), 32'(exp_seq[k-1]));
            chk($sformatf("seq.u0.wrap[%0d]", k),  32'(a_wrap),  32'(k == 15));
            if (k == 1) begin
                chk("steps2.first.state", 32'(b_state), 32'h4);
                chk("steps2.first.out",   32'(b_out),   32'h0);
            end
            if (k == 2) begin
                chk("steps2.second.state", 32'(b_state), 32'h3);
                chk("steps2.second.out",   32'(b_out),   32'h2);
            end
            if (k == 8) begin
                chk("steps2.wrap.state",  32'(b_state),  32'h2);
                chk("steps2.wrap.wrap",   32'(b_wrap),   32'h1);
                chk("steps2.wrap.period", 32'(b_period), 32'd15);
            end
            if (k == 6 || k == 12) begin
                chk($sformatf("taps5.state[%0d]", k),  32'(c_state),  32'h1);
                chk($sformatf("taps5.wrap[%0d]", k),   32'(c_wrap),   32'h1);
                chk($sformatf("taps5.period[%0d]", k), 32'(c_period), 32'd6);
            end
            if (k == 15) begin
                chk("seq.u0.period",       32'(a_period), 32'd15);
                chk("seq.u0.period_valid", 32'(a_pv),     32'h1);
            end
        end

        // Load 1011, then run a full period
        en = 1'b0; load = 1'b1; load_val4 = 4'b1011; load_val8 = 8'hA5;
        cycle("load1011");
        chk("load1011.state", 32'(a_state), 32'hB);
        chk("load1011.pv",    32'(a_pv),    32'h0);
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cycle("run1011");
            chk($sformatf("run1011.wrap[%0d]", k), 32'(a_wrap), 32'(k == 15));
            if (k == 1)  chk("run1011.state1", 32'(a_state), 32'h5);
            if (k == 2)  chk("run1011.state2", 32'(a_state), 32'hA);
            if (k == 15) begin
                chk("run1011.state15", 32'(a_state),  32'hB);
                chk("run1011.period",  32'(a_period), 32'd15);
            end
        end

        // Zero load is rejected
        en = 1'b0; load = 1'b1; load_val4 = 4'h0; load_val8 = 8'h00;
        cycle("load0");
        chk("load0.state",  32'(a_state), 32'h1);
        chk("load0.lockup", 32'(a_lock),  32'h1);
        chk("load0.pv",     32'(a_pv),    32'h0);
        chk("load0.wrap",   32'(a_wrap),  32'h0);
        load = 1'b0;
        cycle("load0.idle");
        chk("load0.lockup_clear", 32'(a_lock), 32'h0);

        // Load wins over en
        load = 1'b1; en = 1'b1; load_val4 = 4'b0110; load_val8 = 8'h3C;
        cycle("load_en");
        chk("load_en.state", 32'(a_state), 32'h6);
        load = 1'b0;
        for (int k = 1; k <= 15; k++) cycle("run0110");
        chk("run0110.state",  32'(a_state),  32'h6);
        chk("run0110.period", 32'(a_period), 32'd15);

        // Asynchronous reset mid-sequence
        load = 1'b1; en = 1'b0; load_val4 = 4'h1; load_val8 = 8'h01;
        cycle("reload");
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 21; k++) cycle("pre_rst");
        chk("pre_rst.state", 32'(a_state), 32'hC);
        chk("pre_rst.pv",    32'(a_pv),    32'h1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) model_reset(i);
        $display("cyc %0d async_rst asserted between edges | u0 %h pv%0b", cyc, a_state, a_pv);
        chk("async_rst.state", 32'(a_state), 32'h1);
        chk("async_rst.pv",    32'(a_pv),    32'h0);
        check_all("async_rst");
        #1 rst = 1'b0;
        cycle("post_rst");
        chk("post_rst.state", 32'(a_state), 32'h2);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            load      = ($urandom_range(0, 15) == 0);
            en        = ($urandom_range(0, 3) != 0);
            load_val4 = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            load_val8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
